// File: rtl/seq_detector_prog_if.sv
// -----------------------------------------------------------------------------
// seq_detector_prog_if
//   Bundles the configuration, serial data and status signals of the
//   programmable sequence detector into a single port.
//
//   Parameters
//     MAX_LEN : longest supported pattern in bits
//     CNT_W   : width of the saturating match counter
//     LEN_W   : width of cfg_len, derived from MAX_LEN
//
//   Signals (direction seen from the detector, i.e. the slave modport)
//     cfg_load    in   latch cfg_pattern / cfg_len / cfg_overlap this cycle
//     cfg_pattern in   pattern, bit cfg_len-1 arrives first, bit 0 last
//     cfg_len     in   pattern length, legal range 1..MAX_LEN
//     cfg_overlap in   1 = overlapping detection, 0 = non-overlapping
//     in_valid    in   qualifies the serial bit
//     in          in   serial data bit
//     count_clr   in   synchronous clear of match_count
//     out         out  registered one-cycle match pulse
//     match_count out  saturating number of matches
//     cfg_err     out  last cfg_load carried an illegal length
//     running     out  detector is in RUN state
//
//   Modports
//     master : the stream / configuration source
//     slave  : the detector itself
// -----------------------------------------------------------------------------
interface seq_detector_prog_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               in_valid;
   logic               in;
   logic               count_clr;
   logic               out;
   logic [CNT_W-1:0]   match_count;
   logic               cfg_err;
   logic               running;

   modport master (
      output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
      output in_valid, in, count_clr,
      input  out, match_count, cfg_err, running
   );

   modport slave (
      input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
      input  in_valid, in, count_clr,
      output out, match_count, cfg_err, running
   );
endinterface

// File: rtl/seq_detector_prog.sv
// -----------------------------------------------------------------------------
// seq_detector_prog
//   Programmable serial bit-sequence detector. A pattern of 1..MAX_LEN bits,
//   its length and the overlap mode are loaded at run time. Each valid input
//   bit is shifted into a history register; when the newest len bits equal the
//   stored pattern a registered one-cycle pulse is raised on out (visible the
//   cycle after the last pattern bit) and a saturating counter increments.
//
//   Ports
//     clk   : system clock, all state changes on the rising edge
//     reset : asynchronous active-low reset, clears everything to IDLE
//     sio   : seq_detector_prog_if.slave
//               cfg_load/cfg_pattern/cfg_len/cfg_overlap - configuration
//               in_valid/in                              - serial stream
//               count_clr                                - counter clear
//               out/match_count/cfg_err/running          - status
//
//   Priority (highest first): reset, cfg_load, data sampling.
//   count_clr is independent of the FSM and beats a same-cycle increment.
// -----------------------------------------------------------------------------
module seq_detector_prog #(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   seq_detector_prog_if.slave      sio
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   // Architectural state
   state_t             state_reg;
   logic [MAX_LEN-1:0] history_reg;
   logic [LEN_W-1:0]   fill_reg;
   logic [MAX_LEN-1:0] pattern_reg;
   logic [LEN_W-1:0]   len_reg;
   logic               overlap_reg;
   logic               out_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               cfg_err_reg;
   logic               running_reg;

   // Next-value / decode signals
   logic [MAX_LEN-1:0] history_next;
   logic [LEN_W-1:0]   fill_next;
   logic [MAX_LEN-1:0] len_mask;
   logic [MAX_LEN-1:0] diff_bits;
   logic               cfg_legal;
   logic               sample_en;
   logic               match_hit;

   // History as it will look after this bit is shifted in; the match is
   // evaluated on this value so the pulse lands on the same edge.
   assign history_next = {history_reg[MAX_LEN-2:0], sio.in};

   // Fill level saturates at MAX_LEN: once the shift register is full every
   // further bit keeps it full.
   assign fill_next = (fill_reg >= MAX_LEN_L) ? MAX_LEN_L : (fill_reg + ONE_L);

   // Only the lowest len_reg bit positions take part in the comparison;
   // bits above the configured length are don't-care.
   generate
      for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_len_mask
         localparam logic [LEN_W-1:0] POS = LEN_W'(gi);
         assign len_mask[gi] = (POS < len_reg);
      end
   endgenerate

   assign diff_bits = (history_next ^ pattern_reg) & len_mask;

   assign cfg_legal = (sio.cfg_len != '0) && (sio.cfg_len <= MAX_LEN_L);

   // A bit is consumed only in RUN, when valid, and not on a load cycle.
   assign sample_en = (state_reg == ST_RUN) && !sio.cfg_load && sio.in_valid;

   // Fill check ensures bits shifted in before a load (or discarded by a
   // non-overlap restart) can never complete a match.
   assign match_hit = sample_en && (fill_next >= len_reg) && (diff_bits == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         history_reg <= '0;
         fill_reg    <= '0;
         pattern_reg <= '0;
         len_reg     <= '0;
         overlap_reg <= 1'b0;
         out_reg     <= 1'b0;
         count_reg   <= '0;
         cfg_err_reg <= 1'b0;
         running_reg <= 1'b0;
      end else begin
         // Match counter: clear wins over a coincident increment.
         if (sio.count_clr) begin
            count_reg <= '0;
         end else if (match_hit && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + CNT_W'(1);
         end

         if (sio.cfg_load) begin
            // Every load restarts detection, legal or not.
            history_reg <= '0;
            fill_reg    <= '0;
            out_reg     <= 1'b0;
            if (cfg_legal) begin
               pattern_reg <= sio.cfg_pattern;
               len_reg     <= sio.cfg_len;
               overlap_reg <= sio.cfg_overlap;
               cfg_err_reg <= 1'b0;
               state_reg   <= ST_RUN;
               running_reg <= 1'b1;
            end else begin
               // Stored configuration is left as it was.
               cfg_err_reg <= 1'b1;
               state_reg   <= ST_IDLE;
               running_reg <= 1'b0;
            end
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  out_reg <= 1'b0;
               end
               ST_RUN: begin
                  if (sio.in_valid) begin
                     history_reg <= history_next;
                     if (match_hit) begin
                        out_reg  <= 1'b1;
                        // Non-overlap: the next match needs len fresh bits.
                        fill_reg <= overlap_reg ? fill_next : '0;
                     end else begin
                        out_reg  <= 1'b0;
                        fill_reg <= fill_next;
                     end
                  end else begin
                     out_reg <= 1'b0;
                  end
               end
               default: begin
                  state_reg   <= ST_IDLE;
                  running_reg <= 1'b0;
                  out_reg     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sio.out         = out_reg;
   assign sio.match_count = count_reg;
   assign sio.cfg_err     = cfg_err_reg;
   assign sio.running     = running_reg;

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Programmable serial bit-sequence detector, parametrised successor of the team's fixed-pattern Mealy detectors. Pattern, length and overlap mode are loaded at run time. It produces a registered one-cycle match pulse, keeps a saturating match counter, and flags illegal configurations. It sits on serial bit streams in front of framing and sync logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter
LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived, not overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset
cfg_load  input  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle
cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit expected, bit 0 the last
cfg_len  input  LEN_W  pattern length, legal 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
in_valid  input  1  in is sampled only when high
in  input  1  serial data bit
count_clr  input  1  synchronous clear of match_count
out  output  1  registered match pulse
match_count  output  CNT_W  saturating count of matches
cfg_err  output  1  last cfg_load had an illegal cfg_len
running  output  1  high in RUN state

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, port named reset. Async assert; release takes effect on the next clk edge.
- Reset values: out=0, match_count=0, cfg_err=0, running=0, history=0, fill=0, stored pattern=0, stored len=0, stored overlap=0, state=IDLE.
- States: IDLE and RUN.
  - IDLE: in/in_valid ignored, out held 0.
  - cfg_load with 1<=cfg_len<=MAX_LEN: go to RUN and set cfg_err=0.
  - cfg_load with cfg_len=0 or cfg_len>MAX_LEN: go to IDLE (from either state), set cfg_err=1 and leave the stored config unchanged.
- Any cfg_load clears history, fill and out in that cycle. The bit presented on that cycle is not sampled. match_count is unaffected.
- RUN, in_valid=1:
  - history <= {history[MAX_LEN-2:0], in}.
  - fill <= min(fill+1, MAX_LEN).
  - Match condition: new fill >= len AND the newest len bits of the new history equal pattern[len-1:0].
  - On a match, out<=1 on the same edge. out is therefore visible the cycle after the last pattern bit was presented (registered Mealy timing).
  - Overlap mode after a match: history and fill are kept.
  - Non-overlap mode after a match: fill<=0, so the next match needs len fresh bits.
- RUN, in_valid=0: history and fill hold; out<=0.
- out is never high for more than one cycle per match. Back-to-back matches give consecutive pulses, e.g. len=1 with a constant matching stream.
- match_count increments by 1 on each match and saturates at 2^CNT_W-1 (no wrap).
- count_clr sets match_count to 0. If count_clr and a match occur in the same cycle, clr wins (result 0). out still pulses.
- Priority, highest first: reset, cfg_load, data sampling.
- Reset asserted mid-pattern discards all progress. The device returns to IDLE and must be reconfigured before any detection.

Test Plan:
- Reset, load pattern=4'b1010, len=4, overlap=1; stream 1,0,1,0,1,0 with in_valid=1 -> out pulses the cycle after bit 4 and after bit 6; match_count=2.
- Same stream with overlap=0, then continue 1,0 -> pulses after bits 4 and 8 only; match_count=2.
- Overlap 1010, stream 1,0,(in_valid=0 for 3 cycles),1,0 -> single pulse after the final valid 0. No pulse or state change during the gap.
- Load len=0 -> cfg_err=1, running=0, out stays 0 on any stream. Then load len=3, pattern=3'b111 -> cfg_err=0, running=1; stream of five 1s with overlap=1 -> pulses after bits 3, 4 and 5.
- CNT_W=2, len=1, pattern=1, ten consecutive 1s -> out high 10 cycles, match_count stops at 3. count_clr asserted together with a match -> match_count=0 while out=1.
- Overlap 1010, feed 1,0,1, then pulse reset low for a partial cycle -> all outputs 0 immediately and state IDLE. After release, feeding 0 gives no pulse. Reload the config, feed 1,0,1,0 -> pulse after the 4th bit.
